// File: rtl/router_fsm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : router_fsm_ctrl
// Brief    : Moore controller sequencing header decode, payload load, full
//            stall and parity check for a three-port packet router.
// Revision : 1.0 - initial release
// ============================================================================
module router_fsm_ctrl (
    input  logic       clock,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       fifo_full,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic       resetn,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    output logic       busy,
    output logic       detect_add,
    output logic       write_enb_reg,
    output logic       ld_state,
    output logic       laf_state,
    output logic       lfd_state,
    output logic       full_state,
    output logic       rst_in_reg
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic       empty_in;
    logic       empty_latched;
    logic       soft_reset_hit;

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Address 3 selects no FIFO, so it never reads as empty.
    always_comb begin
        empty_in      = 1'b0;
        empty_latched = 1'b0;
        case (data_in)
            2'd0:    empty_in = fifo_empty_0;
            2'd1:    empty_in = fifo_empty_1;
            2'd2:    empty_in = fifo_empty_2;
            default: empty_in = 1'b0;
        endcase
        case (addr_q)
            2'd0:    empty_latched = fifo_empty_0;
            2'd1:    empty_latched = fifo_empty_1;
            2'd2:    empty_latched = fifo_empty_2;
            default: empty_latched = 1'b0;
        endcase
    end

    assign soft_reset_hit = (soft_reset_0 && (addr_q == 2'd0)) ||
                            (soft_reset_1 && (addr_q == 2'd1)) ||
                            (soft_reset_2 && (addr_q == 2'd2));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if ((state_q == DECODE_ADDRESS) && pkt_valid)
            addr_d = data_in;

        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid && (data_in != 2'd3))
                    state_d = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_latched)
                    state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    state_d = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_d = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    state_d = LOAD_PARITY;
                else
                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // A timeout on the port being written abandons the packet.
        if (soft_reset_hit)
            state_d = DECODE_ADDRESS;
    end

    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_in_reg    = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_q == LOAD_DATA) ||
                           (state_q == LOAD_AFTER_FULL) ||
                           (state_q == LOAD_PARITY);
    assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

endmodule
`default_nettype wire

// File: tb/tb_router_fsm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_fsm_ctrl
// Brief    : Directed self-checking bench for router_fsm_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_fsm_ctrl;

    // Expected output vectors {busy,detect_add,write_enb_reg,ld,laf,lfd,full,rst_in_reg}
    localparam logic [7:0] C_DA  = 8'b0100_0000;
    localparam logic [7:0] C_LFD = 8'b1000_0100;
    localparam logic [7:0] C_LD  = 8'b0011_0000;
    localparam logic [7:0] C_FFS = 8'b1000_0010;
    localparam logic [7:0] C_LAF = 8'b1010_1000;
    localparam logic [7:0] C_LP  = 8'b1010_0000;
    localparam logic [7:0] C_CPE = 8'b1000_0001;
    localparam logic [7:0] C_WTE = 8'b1000_0000;

    logic       clock = 1'b0;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       fifo_full, pkt_valid, parity_done, low_pkt_valid, resetn;
    logic [1:0] data_in;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       busy, detect_add, write_enb_reg, ld_state;
    logic       laf_state, lfd_state, full_state, rst_in_reg;
    logic [7:0] outs;

    int checks = 0;
    int errors = 0;

    router_fsm_ctrl dut (
        .clock         (clock),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .fifo_full     (fifo_full),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .resetn        (resetn),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .busy          (busy),
        .detect_add    (detect_add),
        .write_enb_reg (write_enb_reg),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .lfd_state     (lfd_state),
        .full_state    (full_state),
        .rst_in_reg    (rst_in_reg)
    );

    always #5 clock = ~clock;

    assign outs = {busy, detect_add, write_enb_reg, ld_state,
                   laf_state, lfd_state, full_state, rst_in_reg};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        checks++;
        assert (outs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, outs, exp);
        end
    endtask

    initial begin
        fifo_empty_0 = 1'b0; fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
        fifo_full = 1'b0; pkt_valid = 1'b0; data_in = 2'd0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        resetn = 1'b1;
        #12;
        chk("reset_state", C_DA);
        resetn = 1'b0;
        tick(); chk("idle_da", C_DA);

        // Normal packet
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
        tick(); chk("n_lfd", C_LFD);
        tick(); chk("n_ld", C_LD);
        tick(); chk("n_ld_hold", C_LD);
        pkt_valid = 1'b0;
        tick(); chk("n_lp", C_LP);
        tick(); chk("n_cpe", C_CPE);
        tick(); chk("n_da", C_DA);

        // Full after parity
        pkt_valid = 1'b1;
        tick(); chk("fp_lfd", C_LFD);
        tick(); chk("fp_ld", C_LD);
        pkt_valid = 1'b0;
        tick(); chk("fp_lp", C_LP);
        fifo_full = 1'b1;
        tick(); chk("fp_cpe", C_CPE);
        tick(); chk("fp_ffs", C_FFS);
        tick(); chk("fp_ffs_hold", C_FFS);
        fifo_full = 1'b0;
        tick(); chk("fp_laf", C_LAF);
        parity_done = 1'b1;
        tick(); chk("fp_da", C_DA);
        parity_done = 1'b0;

        // Full mid-packet, low_pkt_valid exit
        pkt_valid = 1'b1;
        tick(); chk("fm_lfd", C_LFD);
        tick(); chk("fm_ld", C_LD);
        fifo_full = 1'b1;
        tick(); chk("fm_ffs", C_FFS);
        fifo_full = 1'b0;
        tick(); chk("fm_laf", C_LAF);
        low_pkt_valid = 1'b1;
        tick(); chk("fm_lp", C_LP);
        low_pkt_valid = 1'b0; pkt_valid = 1'b0;
        tick(); chk("fm_cpe", C_CPE);
        tick(); chk("fm_da", C_DA);

        // Resume load from LAF
        pkt_valid = 1'b1;
        tick(); chk("rl_lfd", C_LFD);
        tick(); chk("rl_ld", C_LD);
        fifo_full = 1'b1; pkt_valid = 1'b0;
        tick(); chk("rl_ffs", C_FFS);
        fifo_full = 1'b0; pkt_valid = 1'b1;
        tick(); chk("rl_laf", C_LAF);
        tick(); chk("rl_ld_again", C_LD);
        pkt_valid = 1'b0;
        tick(); chk("rl_lp", C_LP);
        tick(); chk("rl_cpe", C_CPE);
        tick(); chk("rl_da", C_DA);

        // Wait till empty on port 1, soft resets
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b0; fifo_empty_0 = 1'b1;
        tick(); chk("w_wte", C_WTE);
        data_in = 2'd0;
        tick(); chk("w_wte_latched", C_WTE);
        soft_reset_0 = 1'b1;
        tick(); chk("w_sr0_ignored", C_WTE);
        soft_reset_0 = 1'b0; fifo_empty_1 = 1'b1;
        tick(); chk("w_lfd", C_LFD);
        tick(); chk("w_ld", C_LD);
        soft_reset_2 = 1'b1;
        tick(); chk("w_sr2_ignored", C_LD);
        soft_reset_2 = 1'b0; soft_reset_1 = 1'b1;
        tick(); chk("w_sr1_ld", C_DA);
        soft_reset_1 = 1'b0; data_in = 2'd1; fifo_empty_1 = 1'b0;
        tick(); chk("w_wte2", C_WTE);
        soft_reset_1 = 1'b1;
        tick(); chk("w_sr1_wte", C_DA);
        soft_reset_1 = 1'b0; pkt_valid = 1'b0;
        tick(); chk("w_da_idle", C_DA);

        // Asynchronous reset mid-packet
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
        tick(); chk("ar_lfd", C_LFD);
        tick(); chk("ar_ld", C_LD);
        #2 resetn = 1'b1;
        #1 chk("ar_async", C_DA);
        tick(); chk("ar_held", C_DA);
        #2 resetn = 1'b0;
        data_in = 2'd3;
        tick(); chk("inv_addr", C_DA);
        tick(); chk("inv_addr_hold", C_DA);

        // Port 2 path and its soft reset
        data_in = 2'd2; fifo_empty_2 = 1'b1;
        tick(); chk("p2_lfd", C_LFD);
        tick(); chk("p2_ld", C_LD);
        soft_reset_2 = 1'b1;
        tick(); chk("p2_sr2", C_DA);
        soft_reset_2 = 1'b0; pkt_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/router_fsm_ctrl.md
ROUTER_FSM_CTRL -- requirements
Module: router_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed in positional order below.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 fifo_empty_0 / fifo_empty_1 / fifo_empty_2  input  1 each  output FIFO k is empty.
REQ-004 fifo_full  input  1  currently addressed FIFO is full.
REQ-005 pkt_valid  input  1  packet bytes in progress on the router input.
REQ-006 data_in  input  2  destination address field of the header byte (0, 1, 2 valid; 3 invalid).
REQ-007 parity_done  input  1  parity byte has been loaded.
REQ-008 low_pkt_valid  input  1  pkt_valid fell while the FIFO was full.
REQ-009 resetn  input  1  asynchronous reset, active-high (1 = reset) despite the suffix.
REQ-010 soft_reset_0 / soft_reset_1 / soft_reset_2  input  1 each  timeout soft reset from output port k.
REQ-011 busy, detect_add, write_enb_reg, ld_state, laf_state, lfd_state, full_state, rst_in_reg  output  1 each  state-decoded controls (see REQ-022 to REQ-029).

Function
REQ-012 Moore FSM with states DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY; state advances only on rising clock.
REQ-013 A 2-bit address register SHALL capture data_in on every edge where state = DECODE_ADDRESS and pkt_valid = 1; it holds otherwise.
REQ-014 DECODE_ADDRESS: pkt_valid=1, data_in=k (k in 0..2), fifo_empty_k=1 -> LOAD_FIRST_DATA; pkt_valid=1, data_in=k, fifo_empty_k=0 -> WAIT_TILL_EMPTY; otherwise (including data_in=3) stay.
REQ-015 WAIT_TILL_EMPTY: fifo_empty of the latched address =1 -> LOAD_FIRST_DATA; else stay.
REQ-016 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-017 LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE; else pkt_valid=0 -> LOAD_PARITY; else stay (fifo_full has priority).
REQ-018 FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
REQ-019 LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; else low_pkt_valid=1 -> LOAD_PARITY; else -> LOAD_DATA.
REQ-020 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally; CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
REQ-021 soft_reset_k=1 while latched address = k SHALL force DECODE_ADDRESS at the next edge from any state, overriding REQ-014 to REQ-020; soft resets of non-addressed ports are ignored.
REQ-022 detect_add = 1 only in DECODE_ADDRESS.
REQ-023 lfd_state = 1 only in LOAD_FIRST_DATA.
REQ-024 ld_state = 1 only in LOAD_DATA.
REQ-025 laf_state = 1 only in LOAD_AFTER_FULL.
REQ-026 full_state = 1 only in FIFO_FULL_STATE.
REQ-027 rst_in_reg = 1 only in CHECK_PARITY_ERROR.
REQ-028 write_enb_reg = 1 in LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY.
REQ-029 busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-030 Outputs SHALL be purely combinational from the state register (no input-to-output paths).

Reset
REQ-031 resetn=1 SHALL immediately (asynchronously) force DECODE_ADDRESS and clear the address register to 0; during reset detect_add=1 and all other outputs 0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet; after release the FSM resumes from DECODE_ADDRESS.

Verification
REQ-033 Normal: pkt_valid=1, data_in=0, fifo_empty_0=1 -> LFD, LD (held while pkt_valid=1); drop pkt_valid -> LP, CPE (rst_in_reg=1), fifo_full=0 -> DA (detect_add=1).
REQ-034 Full after parity: as REQ-033 but fifo_full=1 in CPE -> FFS (full_state=1, busy=1); fifo_full=0 -> LAF; parity_done=1 -> DA.
REQ-035 Full mid-packet: in LD set fifo_full=1 -> FFS; clear -> LAF; parity_done=0, low_pkt_valid=1 -> LP -> CPE -> DA.
REQ-036 Resume load: in LAF with parity_done=0, low_pkt_valid=0 -> LD (ld_state=1, write_enb_reg=1, busy=0); then pkt_valid=0 -> LP -> CPE -> DA.
REQ-037 Wait/soft reset: data_in=1, fifo_empty_1=0, pkt_valid=1 -> WTE (busy=1), stays; fifo_empty_1=1 -> LFD; separately soft_reset_1=1 in WTE or LD -> DA next edge, soft_reset_2=1 has no effect.
REQ-038 Async reset: assert resetn=1 between clock edges in LD -> detect_add=1 before next edge; data_in=3 with pkt_valid=1 in DA -> stays DA.
